// File: rtl/wb_master_arbiter.sv
// ----------------------------------------------------------------------------
// wb_master_arbiter
//
// Round-robin arbiter that lets up to WB_NUM_MASTERS requesters (for example
// the 6502 bridge and a DMA/debug engine) share the single Wishbone master
// connection into wb_bus. Arbitration is per transfer: each grant covers
// exactly one access and ends on the slave ack, after which the arbiter
// returns to IDLE and arbitrates again.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   Defined   -> a watchdog counts GRANT cycles without an ack. When it
//                expires, the granted master gets a forced ack with all-ones
//                read data and timeout_o pulses for that cycle.
//   Undefined -> no watchdog. GRANT waits indefinitely and timeout_o is 0.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-high reset
//   mstr_stb_i  per-master strobe / request                [N]
//   mstr_we_i   per-master write enable                    [N]
//   mstr_adr_i  per-master address, master i at [i*AW +: AW]
//   mstr_dat_i  per-master write data, master i at [i*DW +: DW]
//   mstr_ack_o  per-master acknowledge (only the granted lane can be high)
//   mstr_dat_o  read data, replicated on every lane
//   slv_stb_o   strobe to wb_bus
//   slv_we_o    write enable to wb_bus
//   slv_adr_o   address to wb_bus
//   slv_dat_o   write data to wb_bus
//   slv_ack_i   acknowledge from wb_bus
//   slv_dat_i   read data from wb_bus
//   grant_o     registered one-hot grant (all zero in IDLE)
//   timeout_o   one-cycle watchdog expiry pulse
// ----------------------------------------------------------------------------
module wb_master_arbiter #(
  parameter int WB_DATA_WIDTH     = 8,
  parameter int WB_ADDR_WIDTH     = 16,
  parameter int WB_NUM_MASTERS    = 2,
  parameter int WB_TIMEOUT_CYCLES = 255
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_stb_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_we_i,
  input  logic [WB_NUM_MASTERS*WB_ADDR_WIDTH-1:0] mstr_adr_i,
  input  logic [WB_NUM_MASTERS*WB_DATA_WIDTH-1:0] mstr_dat_i,
  output logic [WB_NUM_MASTERS-1:0]               mstr_ack_o,
  output logic [WB_NUM_MASTERS*WB_DATA_WIDTH-1:0] mstr_dat_o,
  output logic                                    slv_stb_o,
  output logic                                    slv_we_o,
  output logic [WB_ADDR_WIDTH-1:0]                slv_adr_o,
  output logic [WB_DATA_WIDTH-1:0]                slv_dat_o,
  input  logic                                    slv_ack_i,
  input  logic [WB_DATA_WIDTH-1:0]                slv_dat_i,
  output logic [WB_NUM_MASTERS-1:0]               grant_o,
  output logic                                    timeout_o
);

  localparam int N  = WB_NUM_MASTERS;
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;

  // The last-served pointer is kept one-hot. Resetting it to the top master
  // makes master 0 the first in line after reset.
  localparam logic [N-1:0] LAST_RST = {1'b1, {(N-1){1'b0}}};

  // Reject configurations outside the supported range at elaboration.
  if (N < 2 || N > 8 || WB_TIMEOUT_CYCLES < 1 || WB_TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("wb_master_arbiter: parameter out of supported range");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e        state_q;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  last_q;

  logic [N-1:0]  above_last_w;
  logic [N-1:0]  req_hi_w;
  logic [N-1:0]  req_pick_w;
  logic [N-1:0]  grant_d;
  logic          granted_stb_w;
  logic          expire_w;
  logic [DW-1:0] rd_data_w;

  // --------------------------------------------------------------------------
  // Round-robin pick
  // --------------------------------------------------------------------------
  // last_q | (last_q - 1) covers the last-served bit and everything below it;
  // its complement is the set of masters that come after it in the rotation.
  assign above_last_w = ~(last_q | (last_q - N'(1)));
  assign req_hi_w     = mstr_stb_i & above_last_w;
  // No requester above the pointer: wrap around and search from master 0.
  assign req_pick_w   = (|req_hi_w) ? req_hi_w : mstr_stb_i;
  // Isolate the lowest set bit, which gives a one-hot grant by construction.
  assign grant_d      = req_pick_w & (~req_pick_w + N'(1));

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = (WB_TIMEOUT_CYCLES > 255) ? 16 : 8;
  // The counter reads 0 on the first GRANT cycle, so the limit-th cycle
  // sees limit-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WB_TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // A real ack on the expiry cycle wins: no forced ack, no timeout pulse.
  assign expire_w = (state_q == GRANT) && !slv_ack_i && (cnt_q == CNT_LAST);
`else
  assign expire_w = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: IDLE arbitrates for one cycle, GRANT holds until ack or abort
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|mstr_stb_i) begin
            grant_q <= grant_d;
            state_q <= GRANT;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end

        GRANT: begin
          if (slv_ack_i || expire_w) begin
            // Completed (or timed out): the granted master becomes the
            // lowest-priority one for the next round.
            last_q  <= grant_q;
            grant_q <= '0;
            state_q <= IDLE;
          end else if (!granted_stb_w) begin
            // Master gave up before the ack. It was not served, so the
            // rotation pointer stays where it was.
            grant_q <= '0;
            state_q <= IDLE;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end

        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Request path mux (AND-OR on the one-hot grant, so IDLE drives zeros)
  // --------------------------------------------------------------------------
  logic [AW-1:0] adr_term [N];
  logic [DW-1:0] dat_term [N];

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_lane
    assign adr_term[gi] = mstr_adr_i[gi*AW +: AW] & {AW{grant_q[gi]}};
    assign dat_term[gi] = mstr_dat_i[gi*DW +: DW] & {DW{grant_q[gi]}};
    // Read data goes to every lane; only the acked master consumes it.
    assign mstr_dat_o[gi*DW +: DW] = rd_data_w;
  end

  always_comb begin
    slv_adr_o = '0;
    slv_dat_o = '0;
    for (int i = 0; i < N; i++) begin
      slv_adr_o = slv_adr_o | adr_term[i];
      slv_dat_o = slv_dat_o | dat_term[i];
    end
  end

  assign granted_stb_w = |(grant_q & mstr_stb_i);
  assign slv_stb_o     = granted_stb_w;
  assign slv_we_o      = |(grant_q & mstr_we_i);

  // --------------------------------------------------------------------------
  // Response path
  // --------------------------------------------------------------------------
  assign rd_data_w  = expire_w ? {DW{1'b1}} : slv_dat_i;
  assign mstr_ack_o = grant_q & {N{slv_ack_i | expire_w}};
  assign grant_o    = grant_q;
  assign timeout_o  = expire_w;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_master_arbiter
//
// Directed bench for wb_master_arbiter with two 8-bit masters. Inputs are
// driven on the falling edge; outputs are sampled 1 ns later, well away from
// the rising edge. The watchdog scenario is built only when
// WB_ARB_TIMEOUT_EN is defined (limit set to 4 cycles here); otherwise a
// long-stall scenario confirms that GRANT waits and timeout_o stays 0.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_master_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      stb = '0;
  logic [N-1:0]      we  = '0;
  logic [N*AW-1:0]   adr = '0;
  logic [N*DW-1:0]   wdat = '0;
  logic [N-1:0]      ack;
  logic [N*DW-1:0]   rdat;
  logic              sstb;
  logic              swe;
  logic [AW-1:0]     sadr;
  logic [DW-1:0]     sdat;
  logic              sack = 1'b0;
  logic [DW-1:0]     srdat = '0;
  logic [N-1:0]      grant;
  logic              tmo;

  int checks = 0;
  int errors = 0;

  wb_master_arbiter #(
    .WB_DATA_WIDTH     (DW),
    .WB_ADDR_WIDTH     (AW),
    .WB_NUM_MASTERS    (N),
    .WB_TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mstr_stb_i (stb),
    .mstr_we_i  (we),
    .mstr_adr_i (adr),
    .mstr_dat_i (wdat),
    .mstr_ack_o (ack),
    .mstr_dat_o (rdat),
    .slv_stb_o  (sstb),
    .slv_we_o   (swe),
    .slv_adr_o  (sadr),
    .slv_dat_o  (sdat),
    .slv_ack_i  (sack),
    .slv_dat_i  (srdat),
    .grant_o    (grant),
    .timeout_o  (tmo)
  );

  always #5 clk = ~clk;

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1, "time limit");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    stb = 2'b11; we = 2'b11; adr = {16'hAAAA, 16'h5555}; wdat = 16'hFFFF;
    step(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (sstb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", sstb); end
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", ack); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", tmo); end
    checks++; if (swe !== 1'b0 || sadr !== 16'h0000 || sdat !== 8'h00) begin
      errors++; $display("FAIL reset_mux: got we=%b adr=%h dat=%h expected 0/0000/00", swe, sadr, sdat); end
    stb = '0; we = '0; adr = '0; wdat = '0;
    step();
    rst = 1'b0;
    $display("reset released");
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single_read();
    step(); stb = 2'b01; adr[15:0] = 16'h0010; we = 2'b00; #1;
    checks++; if (grant !== 2'b00 || sstb !== 1'b0) begin
      errors++; $display("FAIL single_arb_cycle: got grant=%b stb=%b expected 00/0", grant, sstb); end
    step(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
    checks++; if (sstb !== 1'b1 || sadr !== 16'h0010 || swe !== 1'b0) begin
      errors++; $display("FAIL single_req: got stb=%b adr=%h we=%b expected 1/0010/0", sstb, sadr, swe); end
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL single_early_ack: got %b expected 00", ack); end
    step(); #1;
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL single_wait_ack: got %b expected 00", ack); end
    step(); sack = 1'b1; srdat = 8'h5A; #1;
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL single_ack: got %b expected 01", ack); end
    checks++; if (rdat !== 16'h5A5A) begin errors++; $display("FAIL single_rdata: got %h expected 5a5a", rdat); end
    $display("xfer m0 read adr=%h dat=%h ack=%b", sadr, rdat[7:0], ack);
    step(); sack = 1'b0; stb = 2'b00; #1;
    checks++; if (grant !== 2'b00 || sstb !== 1'b0 || sadr !== 16'h0000) begin
      errors++; $display("FAIL single_back_idle: got grant=%b stb=%b adr=%h expected 00/0/0000", grant, sstb, sadr); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [N-1:0]  exp_g;
    logic [AW-1:0] exp_a;
    apply_reset();
    step(); stb = 2'b11; adr = {16'h2222, 16'h1111}; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_arb_cycle: got %b expected 00", grant); end
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (t % 2 == 0) ? 16'h1111 : 16'h2222;
      step(); sack = 1'b1; srdat = 8'(t); #1;
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", t, grant, exp_g); end
      checks++; if (sadr !== exp_a) begin errors++; $display("FAIL rr_adr%0d: got %h expected %h", t, sadr, exp_a); end
      checks++; if (ack !== exp_g) begin errors++; $display("FAIL rr_ack%0d: got %b expected %b", t, ack, exp_g); end
      $display("xfer rr%0d grant=%b adr=%h ack=%b", t, grant, sadr, ack);
      step(); sack = 1'b0; if (t == 3) stb = 2'b00; #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_idle%0d: got %b expected 00", t, grant); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_write_m1();
    step(); stb = 2'b10; we = 2'b10; adr = {16'hF004, 16'h1234}; wdat = {8'hC3, 8'h11}; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wr_arb_cycle: got %b expected 00", grant); end
    step(); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b expected 10", grant); end
    checks++; if (swe !== 1'b1 || sadr !== 16'hF004 || sdat !== 8'hC3) begin
      errors++; $display("FAIL wr_req: got we=%b adr=%h dat=%h expected 1/f004/c3", swe, sadr, sdat); end
    step(); sack = 1'b1; #1;
    checks++; if (ack !== 2'b10) begin errors++; $display("FAIL wr_ack: got %b expected 10", ack); end
    $display("xfer m1 write adr=%h dat=%h ack=%b", sadr, sdat, ack);
    step(); sack = 1'b0; stb = 2'b00; we = 2'b00; #1;
    checks++; if (grant !== 2'b00 || ack !== 2'b00 || swe !== 1'b0) begin
      errors++; $display("FAIL wr_back_idle: got grant=%b ack=%b we=%b expected 00/00/0", grant, ack, swe); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_abort();
    step(); stb = 2'b01; adr = {16'h0080, 16'h0040}; wdat = '0; #1;
    step(); #1;
    checks++; if (grant !== 2'b01 || sadr !== 16'h0040) begin
      errors++; $display("FAIL abort_grant: got grant=%b adr=%h expected 01/0040", grant, sadr); end
    step(); stb = 2'b00; #1;
    checks++; if (sstb !== 1'b0 || ack !== 2'b00) begin
      errors++; $display("FAIL abort_drop: got stb=%b ack=%b expected 0/00", sstb, ack); end
    step(); stb = 2'b11; #1;
    checks++; if (grant !== 2'b00 || ack !== 2'b00) begin
      errors++; $display("FAIL abort_idle: got grant=%b ack=%b expected 00/00", grant, ack); end
    $display("xfer m0 aborted, no ack");
    step(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL abort_regrant: got %b expected 01", grant); end
    step(); sack = 1'b1; #1;
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL abort_ack: got %b expected 01", ack); end
    $display("xfer m0 after abort adr=%h ack=%b", sadr, ack);
    step(); sack = 1'b0; stb = 2'b00; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL abort_end: got %b expected 00", grant); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    step(); stb = 2'b11; #1;
    step(); #1;
    checks++; if (grant !== 2'b10 || sstb !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got grant=%b stb=%b expected 10/1", grant, sstb); end
    #1; rst = 1'b1; #1;
    checks++; if (grant !== 2'b00 || sstb !== 1'b0) begin
      errors++; $display("FAIL arst_immediate: got grant=%b stb=%b expected 00/0", grant, sstb); end
    step(); rst = 1'b0; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arst_hold: got %b expected 00", grant); end
    step(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL arst_first_grant: got %b expected 01", grant); end
    step(); sack = 1'b1; #1;
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL arst_ack: got %b expected 01", ack); end
    $display("xfer m0 after async reset ack=%b", ack);
    step(); sack = 1'b0; stb = 2'b00; #1;
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  // --------------------------------------------------------------------------
  task automatic test_timeout();
    step(); stb = 2'b11; #1;
    for (int c = 1; c <= TO; c++) begin
      step(); #1;
      if (c < TO) begin
        checks++; if (ack !== 2'b00 || tmo !== 1'b0) begin
          errors++; $display("FAIL to_wait%0d: got ack=%b tmo=%b expected 00/0", c, ack, tmo); end
      end else begin
        checks++; if (ack !== 2'b10 || tmo !== 1'b1) begin
          errors++; $display("FAIL to_expire: got ack=%b tmo=%b expected 10/1", ack, tmo); end
        checks++; if (rdat !== 16'hFFFF) begin errors++; $display("FAIL to_rdata: got %h expected ffff", rdat); end
        $display("xfer m1 timed out ack=%b dat=%h", ack, rdat[7:0]);
      end
    end
    step(); #1;
    checks++; if (grant !== 2'b00 || tmo !== 1'b0) begin
      errors++; $display("FAIL to_idle: got grant=%b tmo=%b expected 00/0", grant, tmo); end
    step(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL to_next: got %b expected 01", grant); end
    step(); sack = 1'b1; srdat = 8'h77; #1;
    checks++; if (ack !== 2'b01 || rdat[7:0] !== 8'h77 || tmo !== 1'b0) begin
      errors++; $display("FAIL to_next_ack: got ack=%b dat=%h tmo=%b expected 01/77/0", ack, rdat[7:0], tmo); end
    $display("xfer m0 after timeout ack=%b dat=%h", ack, rdat[7:0]);
    step(); sack = 1'b0; stb = 2'b00; #1;
  endtask
`else
  // --------------------------------------------------------------------------
  task automatic test_no_timeout();
    step(); stb = 2'b01; #1;
    for (int c = 1; c <= 10; c++) begin
      step(); #1;
      checks++; if (grant !== 2'b01 || ack !== 2'b00 || tmo !== 1'b0) begin
        errors++; $display("FAIL stall%0d: got grant=%b ack=%b tmo=%b expected 01/00/0", c, grant, ack, tmo); end
    end
    step(); sack = 1'b1; srdat = 8'h3C; #1;
    checks++; if (ack !== 2'b01 || rdat[7:0] !== 8'h3C) begin
      errors++; $display("FAIL stall_ack: got ack=%b dat=%h expected 01/3c", ack, rdat[7:0]); end
    $display("xfer m0 after 10-cycle stall ack=%b dat=%h", ack, rdat[7:0]);
    step(); sack = 1'b0; stb = 2'b00; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL stall_end: got %b expected 00", grant); end
  endtask
`endif

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_m1();
    test_abort();
    test_async_reset();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
